signed_bcd_display: RTL and testbench

Parametrised, sequential signed-binary to multi-digit seven-segment display driver. It accepts a two's-complement value through a start/busy/done handshake and converts its magnitude to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It holds the result and drives one `seven_segment` instance per digit. It replaces the fixed 4-digit, 12-bit combinational divider/modulo decoder. It adds:
- explicit sign and overflow outputs
- correct handling of zero and the most-negative input
- optional leading-zero blanking

---
 rtl/signed_bcd_display.sv | 170 +++++++++++++++++
 tb/tb_signed_bcd_display.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_bcd_display.sv
// signed_bcd_display: signed binary to DIGITS-digit 7-seg driver (double-dabble).
// Build option LEADING_ZERO_BLANK_EN blanks zero digits above the top non-zero one.
module seven_segment (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // active-low {g,f,e,d,c,b,a} decode
  always_comb begin
    case (bcd)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

module signed_bcd_display #(
  parameter int         WIDTH     = 12,
  parameter int         DIGITS    = 4,
  parameter logic [6:0] BLANK_PAT = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  neg_o,
  output logic                  ovf_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o
);

  function automatic int calc_digits(input int w);
    longint unsigned lim;
    longint unsigned p;
    int d;
    lim = (64'd1 << w) - 64'd1;
    p = 64'd1;
    d = 0;
    while (p <= lim) begin
      p = p * 64'd10;
      d++;
    end
    return d;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int NAT   = calc_digits(WIDTH);
  localparam int ACC_N = (NAT > DIGITS) ? NAT : DIGITS;
  localparam int ACC_W = 4 * ACC_N;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam logic [63:0] LIM = pow10(DIGITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] sh;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] adj;
  logic [CW-1:0]    cnt;
  logic             neg_s;
  logic             ovf_s;

  // magnitude; the most-negative value maps onto itself as unsigned
  always_comb begin
    mag = data_i[WIDTH-1] ? (~data_i + WIDTH'(1)) : data_i;
  end

  // add 3 to every nibble of 5 or more before the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < ACC_N; i++) begin
      if (acc[4*i+:4] >= 4'd5) adj[4*i+:4] = acc[4*i+:4] + 4'd3;
    end
  end

  // conversion FSM with registered handshake and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_s  <= 1'b0;
      ovf_s  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      neg_o  <= 1'b0;
      ovf_o  <= 1'b0;
      bcd_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            sh     <= mag;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            neg_s  <= data_i[WIDTH-1];
            ovf_s  <= (64'(mag) >= LIM);
            busy_o <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // top accumulator bit is always 0; rotating it keeps every bit live
          {acc, sh} <= {adj[ACC_W-2:0], sh, adj[ACC_W-1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_o  <= {adj[4*DIGITS-2:0], sh[WIDTH-1]};
            neg_o  <= neg_s;
            ovf_o  <= ovf_s;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] dec;

`ifdef LEADING_ZERO_BLANK_EN
  // blank zeros above the most-significant non-zero digit, never on overflow
  always_comb begin
    logic lead;
    lead  = !ovf_o;
    blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (bcd_o[4*k+:4] != 4'd0) lead = 1'b0;
      blank[k] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seven_segment u_seg (
      .bcd (bcd_o[4*k+:4]),
      .seg (dec[7*k+:7])
    );
    assign seg_o[7*k+:7] = blank[k] ? BLANK_PAT : dec[7*k+:7];
  end

endmodule

// File: tb/tb_signed_bcd_display.sv
// tb_signed_bcd_display: random + directed checks of two display widths
// against a decimal-arithmetic reference model.
module tb_signed_bcd_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] data = '0;

  logic        busy4, done4, neg4, ovf4;
  logic [15:0] bcd4;
  logic [27:0] seg4;
  logic        busy3, done3, neg3, ovf3;
  logic [11:0] bcd3;
  logic [20:0] seg3;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  signed_bcd_display #(.WIDTH(12), .DIGITS(4), .BLANK_PAT(7'h7F)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .data_i(data),
    .busy_o(busy4), .done_o(done4), .neg_o(neg4), .ovf_o(ovf4),
    .bcd_o(bcd4), .seg_o(seg4)
  );

  signed_bcd_display #(.WIDTH(12), .DIGITS(3), .BLANK_PAT(7'h7F)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .data_i(data),
    .busy_o(busy3), .done_o(done3), .neg_o(neg3), .ovf_o(ovf3),
    .bcd_o(bcd3), .seg_o(seg3)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int abs_of(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] bcd_of(input int v, input int d);
    logic [31:0] r;
    int m;
    r = '0;
    m = abs_of(v);
    for (int i = 0; i < d; i++) begin
      r[4*i+:4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ovf_of(input int v, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return abs_of(v) >= p;
  endfunction

  function automatic logic [55:0] seg_of(input int v, input int d);
    logic [31:0] b;
    logic [55:0] s;
    logic o;
    int hi;
    b = bcd_of(v, d);
    o = ovf_of(v, d);
    hi = 0;
    s = '0;
    for (int i = 0; i < d; i++) if (b[4*i+:4] != 4'd0) hi = i;
    for (int i = 0; i < d; i++)
      s[7*i+:7] = (BLANK && !o && i > hi) ? 7'h7F : SEG_TAB[b[4*i+:4]];
    return s;
  endfunction

  // reference model: cycles left in conversion plus last converted value
  int m_left;
  int m_pend;
  int m_val;
  bit m_busy;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_pend <= 0;
      m_val  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= 12;
          m_busy <= 1'b1;
          m_pend <= int'($signed(data));
        end
      end else if (m_left == 1) begin
        m_left <= 0;
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_val  <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy4", busy4, m_busy);
      check("done4", done4, m_done);
      check("neg4", neg4, m_val < 0);
      check("ovf4", ovf4, ovf_of(m_val, 4));
      check("bcd4", bcd4, bcd_of(m_val, 4));
      check("seg4", seg4, seg_of(m_val, 4));
      check("busy3", busy3, m_busy);
      check("done3", done3, m_done);
      check("neg3", neg3, m_val < 0);
      check("ovf3", ovf3, ovf_of(m_val, 3));
      check("bcd3", bcd3, bcd_of(m_val, 3));
      check("seg3", seg3, seg_of(m_val, 3));
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (done4) break;
      n++;
    end
    if (n == 40) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected done pulse");
    end
  endtask

  task automatic kick(input int v);
    @(posedge clk);
    #2;
    start = 1'b1;
    data = 12'(v);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run(input int v);
    kick(v);
    wait_done();
  endtask

  logic [11:0] edge_vals [6] = '{12'h800, 12'h7FF, 12'h000, 12'hFFF,
                                 12'd999, 12'd1000};

  initial begin
    int dn;
    #1;
    cmp_en = 1'b1;
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_bcd", bcd4, 16'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    run(1234);
    check("d_1234_bcd4", bcd4, 16'h1234);
    check("d_1234_neg4", neg4, 1'b0);
    check("d_1234_ovf4", ovf4, 1'b0);
    check("d_1234_bcd3", bcd3, 12'h234);
    check("d_1234_ovf3", ovf3, 1'b1);

    run(-2048);
    check("d_m2048_bcd4", bcd4, 16'h2048);
    check("d_m2048_neg4", neg4, 1'b1);

    run(0);
    check("d_0_bcd4", bcd4, 16'h0);
    check("d_0_neg4", neg4, 1'b0);
    if (BLANK) check("d_0_seg4", seg4, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    else       check("d_0_seg4", seg4, {4{7'h40}});

    run(999);
    check("d_999_bcd3", bcd3, 12'h999);
    check("d_999_ovf3", ovf3, 1'b0);

    kick(1234);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    data = 12'd555;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done();
    check("ign_bcd4", bcd4, 16'h1234);
    run(555);
    check("d_555_bcd4", bcd4, 16'h0555);

    run(42);
    if (BLANK) begin
      check("blk_d3", seg4[27:21], 7'h7F);
      check("blk_d2", seg4[20:14], 7'h7F);
    end else begin
      check("blk_d3", seg4[27:21], 7'h40);
      check("blk_d2", seg4[20:14], 7'h40);
    end
    check("blk_d1", seg4[13:7], 7'h19);
    check("blk_d0", seg4[6:0], 7'h24);

    kick(-7);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_neg", neg4, 1'b0);
    check("abort_ovf", ovf4, 1'b0);
    check("abort_bcd", bcd4, 16'h0);
    if (!BLANK) check("abort_seg", seg4, {4{7'h40}});
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done4 || done3) dn++;
    end
    check("abort_no_done", dn, 0);

    repeat (3000) begin
      @(posedge clk);
      #2;
      start = ($urandom % 3) != 0;
      if ($urandom % 8 == 0) data = edge_vals[$urandom % 6];
      else data = 12'($urandom);
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
